cam_fill_ctrl: RTL and testbench
================================

Name: cam_fill_ctrl

Overview:
Controller that owns the update port of a `cam` instance and serialises fill, invalidate and flush requests into legal CAM writes. It probes the CAM lookup port before each write, so it never writes a duplicate key. It picks the victim slot for each fill and returns the resulting index to the requester. It sits between a TLB or tag-miss handler and its CAM.

Parameters:
NUM_ENTRIES, 16, number of CAM slots; any value ≥2.
KEY_WIDTH, 32, key width.
INDEX_WIDTH, $clog2(NUM_ENTRIES), slot index width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready at clk edge
req_op  in  2  0=FILL, 1=INVAL, 2=FLUSH, 3=reserved (no-op)
req_key  in  KEY_WIDTH  key for FILL/INVAL
resp_valid  out  1  one-cycle completion pulse
resp_idx  out  INDEX_WIDTH  slot written or matched
resp_hit  out  1  key already present (FILL) / found (INVAL)
resp_evicted  out  1  FILL overwrote a valid entry
cam_lookup_key  out  KEY_WIDTH  to CAM lookup_key
cam_lookup_idx  in  INDEX_WIDTH  from CAM lookup_idx (async)
cam_lookup_hit  in  1  from CAM lookup_hit (async)
cam_update_en  out  1  to CAM update_en
cam_update_key  out  KEY_WIDTH  to CAM update_key
cam_update_idx  out  INDEX_WIDTH  to CAM update_idx
cam_update_valid  out  1  to CAM update_valid

Behaviour:
- States: IDLE, LOOKUP, COMMIT, FLUSH. req_ready = (state==IDLE).
- Reset: state IDLE, so req_ready=1. shadow_valid[NUM_ENTRIES]=0. rr_ptr=0. resp_valid, resp_hit, resp_evicted, cam_update_en, cam_update_valid = 0. resp_idx, cam_update_idx = 0.
- Reset mid-operation aborts the request: no update_en and no resp for it.
- Accept (edge E0): latch op and key.
  - FLUSH goes to FLUSH.
  - Any other op goes to LOOKUP.
- LOOKUP (1 cycle):
  - cam_lookup_key = latched key.
  - Register cam_lookup_hit/cam_lookup_idx and the victim, then go to COMMIT.
  - cam_lookup_key holds latched key in all states; only sampled in LOOKUP.
- Victim selection:
  - If any shadow_valid bit is 0, use the lowest-index invalid slot.
  - Otherwise use rr_ptr; rr_ptr then increments, wrapping NUM_ENTRIES-1 → 0.
  - rr_ptr advances only on an eviction.
- COMMIT (1 cycle): resp_valid=1; all cam_update_* and resp_* are registered outputs. Then go to IDLE.
  - FILL, hit: no write; resp_hit=1, resp_idx=hit idx.
  - FILL, miss: update_en=1, key=latched key, idx=victim, valid=1; shadow_valid[victim]←1; resp_idx=victim, resp_evicted=old shadow_valid[victim].
  - INVAL, hit: update_en=1, idx=hit idx, valid=0, key=latched key; shadow_valid cleared; resp_hit=1.
  - INVAL, miss: no write; resp_hit=0.
  - Op 3: no write; resp_hit=0, resp_evicted=0.
- Latency: FILL/INVAL give resp_valid in cycle E0+2; req_ready returns in E0+3.
- FLUSH:
  - Counter runs 0..NUM_ENTRIES-1, one per cycle, driving update_en=1, valid=0, idx=counter, key=latched key.
  - resp_valid=1 in the cycle idx=NUM_ENTRIES-1, with resp_idx=NUM_ENTRIES-1, resp_hit=0.
  - After that cycle: shadow_valid=0, rr_ptr=0, state IDLE.
- Outputs outside COMMIT/FLUSH: cam_update_en=0, resp_valid=0.
- resp_hit/resp_evicted are meaningful only while resp_valid=1.
- CAM same-cycle update/lookup hazard cannot occur: lookup and update of one request are in separate cycles, and requests are serialised.
- Assertions:
  - cam_lookup_hit in LOOKUP implies shadow_valid[cam_lookup_idx]=1.
  - No FILL miss ever writes a key currently present.

Test Plan:
- Config: NUM_ENTRIES=4, KEY_WIDTH=32.
- Reset, FILL 0x100,0x200,0x300,0x400 → resp_idx 0,1,2,3, hit=0, evicted=0; update_en exactly at E0+2, valid=1.
- FILL 0x200 → resp_hit=1, resp_idx=1, no update_en pulse.
- Table full: FILL 0x500 → idx 0, evicted=1; then FILL 0x600 → idx 1, evicted=1.
- INVAL 0x300 → update_en idx 2, valid=0, resp_hit=1. Then FILL 0x700 → idx 2, evicted=0, rr_ptr unchanged (next eviction idx 2). INVAL 0x999 → resp_hit=0, no write.
- FLUSH → update_en in 4 consecutive cycles, idx 0,1,2,3, valid=0; resp_valid only with idx 3; req_ready=0 throughout. Then FILL 0xA00 → idx 0, evicted=0.
- Reset asserted during LOOKUP of a FILL → no update_en, no resp_valid; req_ready=1 after reset; next FILL → idx 0, evicted=0.

Source files
------------

// File: rtl/cam_fill_ctrl_if.sv
// Request/response channel between a miss handler (master) and cam_fill_ctrl (slave).
// The miss handler issues FILL/INVAL/FLUSH requests and receives a one-cycle completion pulse.
interface cam_fill_ctrl_if #(
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [KEY_WIDTH-1:0]   req_key;
  logic                   resp_valid;
  logic [INDEX_WIDTH-1:0] resp_idx;
  logic                   resp_hit;
  logic                   resp_evicted;

  modport master (
    output req_valid, req_op, req_key,
    input  req_ready, resp_valid, resp_idx, resp_hit, resp_evicted
  );

  modport slave (
    input  req_valid, req_op, req_key,
    output req_ready, resp_valid, resp_idx, resp_hit, resp_evicted
  );
endinterface

// File: rtl/cam_fill_ctrl.sv
// Serialises fill/invalidate/flush requests into CAM writes, probing the CAM before every
// write so a key is never duplicated; picks fill victims (free slot first, else round-robin).
module cam_fill_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  cam_fill_ctrl_if.slave         bus,
  output logic [KEY_WIDTH-1:0]   cam_lookup_key,
  input  logic [INDEX_WIDTH-1:0] cam_lookup_idx,
  input  logic                   cam_lookup_hit,
  output logic                   cam_update_en,
  output logic [KEY_WIDTH-1:0]   cam_update_key,
  output logic [INDEX_WIDTH-1:0] cam_update_idx,
  output logic                   cam_update_valid
);

  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT, FLUSH} state_e;
  typedef enum logic [1:0] {OP_FILL = 2'd0, OP_INVAL = 2'd1, OP_FLUSH = 2'd2, OP_NOP = 2'd3} op_e;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_ENTRIES - 1);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [NUM_ENTRIES-1:0] shadow_valid_q, shadow_valid_d;
  logic [INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [INDEX_WIDTH-1:0] resp_idx_q, resp_idx_d;
  logic                   resp_hit_q, resp_hit_d;
  logic                   resp_evicted_q, resp_evicted_d;
  logic                   upd_en_q, upd_en_d;
  logic [KEY_WIDTH-1:0]   upd_key_q, upd_key_d;
  logic [INDEX_WIDTH-1:0] upd_idx_q, upd_idx_d;
  logic                   upd_valid_q, upd_valid_d;

  logic [INDEX_WIDTH-1:0] victim;
  logic                   all_valid;
  logic [INDEX_WIDTH-1:0] rr_next;

  // Lowest free slot wins; only a full table falls back to the round-robin pointer.
  always_comb begin
    victim = rr_ptr_q;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!shadow_valid_q[i]) victim = INDEX_WIDTH'(i);
    end
  end

  assign all_valid = &shadow_valid_q;
  assign rr_next   = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + 1'b1;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d        = state_q;
    op_d           = op_q;
    key_d          = key_q;
    shadow_valid_d = shadow_valid_q;
    rr_ptr_d       = rr_ptr_q;
    resp_valid_d   = 1'b0;
    resp_idx_d     = '0;
    resp_hit_d     = 1'b0;
    resp_evicted_d = 1'b0;
    upd_en_d       = 1'b0;
    upd_key_d      = upd_key_q;
    upd_idx_d      = '0;
    upd_valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d  = op_e'(bus.req_op);
          key_d = bus.req_key;
          if (op_e'(bus.req_op) == OP_FLUSH) begin
            state_d   = FLUSH;
            upd_en_d  = 1'b1;
            upd_key_d = bus.req_key;
          end else begin
            state_d = LOOKUP;
          end
        end
      end

      // The CAM answers combinationally here; the outcome lands in the registered outputs.
      LOOKUP: begin
        state_d      = COMMIT;
        resp_valid_d = 1'b1;
        upd_key_d    = key_q;
        unique case (op_q)
          OP_FILL: begin
            if (cam_lookup_hit) begin
              resp_hit_d = 1'b1;
              resp_idx_d = cam_lookup_idx;
            end else begin
              upd_en_d               = 1'b1;
              upd_valid_d            = 1'b1;
              upd_idx_d              = victim;
              resp_idx_d             = victim;
              resp_evicted_d         = shadow_valid_q[victim];
              shadow_valid_d[victim] = 1'b1;
              if (all_valid) rr_ptr_d = rr_next;
            end
          end
          OP_INVAL: begin
            if (cam_lookup_hit) begin
              upd_en_d                       = 1'b1;
              upd_idx_d                      = cam_lookup_idx;
              resp_hit_d                     = 1'b1;
              resp_idx_d                     = cam_lookup_idx;
              shadow_valid_d[cam_lookup_idx] = 1'b0;
            end
          end
          default: ;
        endcase
      end

      COMMIT: state_d = IDLE;

      // The update index doubles as the flush counter.
      FLUSH: begin
        if (upd_idx_q == LAST_IDX) begin
          state_d        = IDLE;
          shadow_valid_d = '0;
          rr_ptr_d       = '0;
        end else begin
          upd_en_d  = 1'b1;
          upd_idx_d = upd_idx_q + 1'b1;
          if (upd_idx_q + 1'b1 == LAST_IDX) begin
            resp_valid_d = 1'b1;
            resp_idx_d   = LAST_IDX;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= OP_NOP;
      key_q          <= '0;
      shadow_valid_q <= '0;
      rr_ptr_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_idx_q     <= '0;
      resp_hit_q     <= 1'b0;
      resp_evicted_q <= 1'b0;
      upd_en_q       <= 1'b0;
      upd_key_q      <= '0;
      upd_idx_q      <= '0;
      upd_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      key_q          <= key_d;
      shadow_valid_q <= shadow_valid_d;
      rr_ptr_q       <= rr_ptr_d;
      resp_valid_q   <= resp_valid_d;
      resp_idx_q     <= resp_idx_d;
      resp_hit_q     <= resp_hit_d;
      resp_evicted_q <= resp_evicted_d;
      upd_en_q       <= upd_en_d;
      upd_key_q      <= upd_key_d;
      upd_idx_q      <= upd_idx_d;
      upd_valid_q    <= upd_valid_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_idx     = resp_idx_q;
  assign bus.resp_hit     = resp_hit_q;
  assign bus.resp_evicted = resp_evicted_q;

  assign cam_lookup_key   = key_q;
  assign cam_update_en    = upd_en_q;
  assign cam_update_key   = upd_key_q;
  assign cam_update_idx   = upd_idx_q;
  assign cam_update_valid = upd_valid_q;

  a_lookup_hit_tracked: assert property (@(posedge clk) disable iff (reset)
    (state_q == LOOKUP && cam_lookup_hit) |-> shadow_valid_q[cam_lookup_idx]);

  // The CAM is not written until the end of COMMIT, so a hit here would mean a duplicate.
  a_no_duplicate_fill: assert property (@(posedge clk) disable iff (reset)
    (state_q == COMMIT && upd_en_q && upd_valid_q) |-> !cam_lookup_hit);

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Self-checking bench for cam_fill_ctrl: directed vector table, reset-abort sequence,
// and randomized requests checked against a slot-array reference model.
module tb_cam_fill_ctrl;
  localparam int N  = 4;
  localparam int KW = 32;
  localparam int IW = 2;

  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_INVAL = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  typedef struct {
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [IW-1:0] idx;
    logic          hit;
    logic          ev;
    logic          wr;
    logic          wrv;
    logic          chk_idx;
    logic          chk_ev;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [KW-1:0] cam_lookup_key;
  logic [IW-1:0] cam_lookup_idx;
  logic          cam_lookup_hit;
  logic          cam_update_en;
  logic [KW-1:0] cam_update_key;
  logic [IW-1:0] cam_update_idx;
  logic          cam_update_valid;

  int checks   = 0;
  int failures = 0;

  cam_fill_ctrl_if #(.KEY_WIDTH(KW), .INDEX_WIDTH(IW)) bus ();

  cam_fill_ctrl #(.NUM_ENTRIES(N), .KEY_WIDTH(KW)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .cam_lookup_key   (cam_lookup_key),
    .cam_lookup_idx   (cam_lookup_idx),
    .cam_lookup_hit   (cam_lookup_hit),
    .cam_update_en    (cam_update_en),
    .cam_update_key   (cam_update_key),
    .cam_update_idx   (cam_update_idx),
    .cam_update_valid (cam_update_valid)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: written on update_en, searched combinationally.
  logic [KW-1:0] cam_k [N];
  logic          cam_v [N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cam_v[i] <= 1'b0;
    end else if (cam_update_en) begin
      cam_k[cam_update_idx] <= cam_update_key;
      cam_v[cam_update_idx] <= cam_update_valid;
    end
  end

  always_comb begin
    cam_lookup_hit = 1'b0;
    cam_lookup_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!cam_lookup_hit && cam_v[i] && cam_k[i] == cam_lookup_key) begin
        cam_lookup_hit = 1'b1;
        cam_lookup_idx = IW'(i);
      end
    end
  end

  // Reference model: slot contents plus the round-robin pointer.
  logic [KW-1:0] m_key [N];
  bit            m_vld [N];
  int            m_rr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_vld[i] = 0;
    m_rr = 0;
  endtask

  task automatic model_step(input logic [1:0] op, input logic [KW-1:0] key, output vec_t e);
    int hit_i, free_i, slot;
    hit_i  = -1;
    free_i = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_vld[i] && m_key[i] == key) hit_i = i;
      if (!m_vld[i]) free_i = i;
    end
    e = '{op: op, key: key, idx: '0, hit: 1'b0, ev: 1'b0, wr: 1'b0, wrv: 1'b0,
          chk_idx: 1'b1, chk_ev: 1'b1};
    case (op)
      OP_FILL: begin
        if (hit_i >= 0) begin
          e.idx = IW'(hit_i);
          e.hit = 1'b1;
        end else begin
          if (free_i >= 0) begin
            slot = free_i;
          end else begin
            slot  = m_rr;
            e.ev  = 1'b1;
            m_rr  = (m_rr + 1) % N;
          end
          m_key[slot] = key;
          m_vld[slot] = 1;
          e.idx = IW'(slot);
          e.wr  = 1'b1;
          e.wrv = 1'b1;
        end
      end
      OP_INVAL: begin
        e.chk_ev = 1'b0;
        if (hit_i >= 0) begin
          e.idx = IW'(hit_i);
          e.hit = 1'b1;
          e.wr  = 1'b1;
          m_vld[hit_i] = 0;
        end else begin
          e.chk_idx = 1'b0;
        end
      end
      OP_FLUSH: begin
        e.idx    = IW'(N - 1);
        e.chk_ev = 1'b0;
        model_reset();
      end
      default: e.chk_idx = 1'b0;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [KW-1:0] key, input int idx,
                              input logic hit, input logic ev, input logic wr, input logic wrv,
                              input logic chk_idx, input logic chk_ev);
    vec_t v;
    v = '{op: op, key: key, idx: IW'(idx), hit: hit, ev: ev, wr: wr, wrv: wrv,
          chk_idx: chk_idx, chk_ev: chk_ev};
    return v;
  endfunction

  // Issue one request and compare the whole transaction timeline with e.
  task automatic run_req(input string name, input vec_t e);
    int n_upd, first_upd, n_resp, resp_cyc, ready_cyc;
    int exp_upd, exp_first, exp_resp_cyc, exp_ready;
    logic [IW-1:0] r_idx;
    logic r_hit, r_ev;
    bit flush;
    flush     = (e.op == OP_FLUSH);
    n_upd     = 0;
    first_upd = -1;
    n_resp    = 0;
    resp_cyc  = -1;
    ready_cyc = -1;
    r_idx     = '0;
    r_hit     = 1'b0;
    r_ev      = 1'b0;

    @(negedge clk);
    check({name, " ready_before"}, 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = e.op;
    bus.req_key   = e.key;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;

    for (int c = 1; c <= 24 && ready_cyc < 0; c++) begin
      @(negedge clk);
      if (cam_update_en) begin
        if (flush) begin
          check({name, " flush_idx"}, 32'(cam_update_idx), n_upd);
          check({name, " flush_valid"}, 32'(cam_update_valid), 0);
          check({name, " flush_key"}, cam_update_key, e.key);
        end else if (e.wr) begin
          check({name, " upd_idx"}, 32'(cam_update_idx), 32'(e.idx));
          check({name, " upd_valid"}, 32'(cam_update_valid), 32'(e.wrv));
          check({name, " upd_key"}, cam_update_key, e.key);
        end
        if (first_upd < 0) first_upd = c;
        n_upd++;
      end
      if (bus.resp_valid) begin
        n_resp++;
        resp_cyc = c;
        r_idx    = bus.resp_idx;
        r_hit    = bus.resp_hit;
        r_ev     = bus.resp_evicted;
      end
      if (bus.req_ready) ready_cyc = c;
    end

    if (flush) begin
      exp_upd      = N;
      exp_first    = 1;
      exp_resp_cyc = N;
      exp_ready    = N + 1;
    end else begin
      exp_upd      = e.wr ? 1 : 0;
      exp_first    = e.wr ? 2 : -1;
      exp_resp_cyc = 2;
      exp_ready    = 3;
    end

    check({name, " upd_count"}, n_upd, exp_upd);
    check({name, " upd_cycle"}, first_upd, exp_first);
    check({name, " resp_count"}, n_resp, 1);
    check({name, " resp_cycle"}, resp_cyc, exp_resp_cyc);
    check({name, " ready_cycle"}, ready_cyc, exp_ready);
    check({name, " resp_hit"}, 32'(r_hit), 32'(e.hit));
    if (e.chk_idx) check({name, " resp_idx"}, 32'(r_idx), 32'(e.idx));
    if (e.chk_ev)  check({name, " resp_evicted"}, 32'(r_ev), 32'(e.ev));
  endtask

  vec_t tbl [14];
  vec_t ev_scratch;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_upd, seen_resp;
    logic [1:0] rop;
    int r;

    tbl[0]  = mk(OP_FILL,  32'h100, 0, 0, 0, 1, 1, 1, 1);
    tbl[1]  = mk(OP_FILL,  32'h200, 1, 0, 0, 1, 1, 1, 1);
    tbl[2]  = mk(OP_FILL,  32'h300, 2, 0, 0, 1, 1, 1, 1);
    tbl[3]  = mk(OP_FILL,  32'h400, 3, 0, 0, 1, 1, 1, 1);
    tbl[4]  = mk(OP_FILL,  32'h200, 1, 1, 0, 0, 0, 1, 1);
    tbl[5]  = mk(OP_FILL,  32'h500, 0, 0, 1, 1, 1, 1, 1);
    tbl[6]  = mk(OP_FILL,  32'h600, 1, 0, 1, 1, 1, 1, 1);
    tbl[7]  = mk(OP_INVAL, 32'h300, 2, 1, 0, 1, 0, 1, 0);
    tbl[8]  = mk(OP_FILL,  32'h700, 2, 0, 0, 1, 1, 1, 1);
    tbl[9]  = mk(OP_FILL,  32'h800, 2, 0, 1, 1, 1, 1, 1);
    tbl[10] = mk(OP_INVAL, 32'h999, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(OP_NOP,   32'h123, 0, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(OP_FLUSH, 32'hF00, 3, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(OP_FILL,  32'hA00, 0, 0, 0, 1, 1, 1, 1);

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_key   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 1);
    check("rst resp_valid", 32'(bus.resp_valid), 0);
    check("rst resp_hit", 32'(bus.resp_hit), 0);
    check("rst resp_evicted", 32'(bus.resp_evicted), 0);
    check("rst resp_idx", 32'(bus.resp_idx), 0);
    check("rst update_en", 32'(cam_update_en), 0);
    check("rst update_valid", 32'(cam_update_valid), 0);
    check("rst update_idx", 32'(cam_update_idx), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst resp_valid", 32'(bus.resp_valid), 0);

    for (int i = 0; i < 14; i++) begin
      model_step(tbl[i].op, tbl[i].key, ev_scratch);
      run_req($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset while a FILL sits in LOOKUP: the request must vanish without a write or response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_FILL;
    bus.req_key   = 32'hB00;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    seen_upd  = 0;
    seen_resp = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen_upd  += int'(cam_update_en);
      seen_resp += int'(bus.resp_valid);
    end
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen_upd  += int'(cam_update_en);
      seen_resp += int'(bus.resp_valid);
    end
    check("abort update_en", seen_upd, 0);
    check("abort resp_valid", seen_resp, 0);
    check("abort req_ready", 32'(bus.req_ready), 1);
    model_step(OP_FILL, 32'hC00, ev_scratch);
    run_req("after_abort", ev_scratch);

    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      rop = OP_FILL;
      else if (r < 80) rop = OP_INVAL;
      else if (r < 90) rop = OP_NOP;
      else             rop = OP_FLUSH;
      model_step(rop, 32'h10 + 32'($urandom_range(0, 6)), ev_scratch);
      run_req($sformatf("rnd%0d", t), ev_scratch);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
